// File: rtl/bf_sram_arbiter_pkg.sv
// Shared bloom-filter definitions: arbiter FSM state encodings and SRAM client IDs.
package bf_sram_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;

  // Client 0 is the aging engine, client 1 the packet engine; also the read-return tag value.
  localparam logic CLIENT_AGE = 1'b0;
  localparam logic CLIENT_PKT = 1'b1;

endpackage

// File: rtl/bf_sram_arbiter_fifo.sv
// Small fallthrough FIFO: the head entry is visible on dout whenever the FIFO is non-empty.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 1,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  // The count can only reach DEPTH, so its MSB alone marks full.
  assign full  = count[MAX_DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bf_sram_arbiter.sv
// Two-client SRAM arbiter for the bloom filter: aging engine (c0) and packet engine (c1)
// share one read port and one write port; read data is routed back via an in-order tag FIFO.
module bf_sram_arbiter
  import bf_sram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             c0_req,
  input  logic                             c0_wr,
  input  logic [SRAM_ADDR_WIDTH-1:0]       c0_addr,
  input  logic [DATA_WIDTH-1:0]            c0_wdata,
  output logic                             c0_gnt,
  output logic                             c0_rvld,
  output logic [DATA_WIDTH-1:0]            c0_rdata,
  input  logic                             c1_req,
  input  logic                             c1_wr,
  input  logic [SRAM_ADDR_WIDTH-1:0]       c1_addr,
  input  logic [DATA_WIDTH-1:0]            c1_wdata,
  output logic                             c1_gnt,
  output logic                             c1_rvld,
  output logic [DATA_WIDTH-1:0]            c1_rdata,
  output logic                             rd_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0]       rd_0_addr,
  input  logic                             rd_0_ack,
  input  logic                             rd_0_vld,
  input  logic [DATA_WIDTH-1:0]            rd_0_data,
  output logic                             wr_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0]       wr_0_addr,
  output logic [DATA_WIDTH-1:0]            wr_0_data,
  input  logic                             wr_0_ack,
  output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding,
  output logic                             err_orphan_vld
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [1:0]                 state;
  logic [STARVE_W-1:0]        starve_cnt;
  logic                       can_read, elig0, elig1, c0_first, pick0, pick1, grant_rd;
  logic                       sel_wr, tag_in, tag_out, tag_full, tag_empty, pop;
  logic [SRAM_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]      sel_wdata;

  // The tag FIFO holds exactly the outstanding reads, so full means rd_outstanding == MAX_OUTSTANDING.
  assign can_read = !tag_full;
  assign elig0    = c0_req && (c0_wr || can_read);
  assign elig1    = c1_req && (c1_wr || can_read);
  assign c0_first = (starve_cnt >= STARVE_MAX);
  assign pick1    = !reset && (state == ST_IDLE) && elig1 && !(c0_first && elig0);
  assign pick0    = !reset && (state == ST_IDLE) && elig0 && !pick1;
  assign c0_gnt   = pick0;
  assign c1_gnt   = pick1;
  assign grant_rd = (pick0 || pick1) && !sel_wr;
  assign tag_in   = pick1 ? CLIENT_PKT : CLIENT_AGE;
  assign pop      = rd_0_vld && !tag_empty;

  always_comb begin
    sel_wr    = c0_wr;
    sel_addr  = c0_addr;
    sel_wdata = c0_wdata;
    if (pick1) begin
      sel_wr    = c1_wr;
      sel_addr  = c1_addr;
      sel_wdata = c1_wdata;
    end
  end

  fallthrough_small_fifo #(
    .WIDTH          (1),
    .MAX_DEPTH_BITS ($clog2(MAX_OUTSTANDING))
  ) tag_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (tag_in),
    .wr_en (grant_rd),
    .rd_en (pop),
    .dout  (tag_out),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_0_req  <= 1'b0;
      rd_0_addr <= '0;
      wr_0_req  <= 1'b0;
      wr_0_addr <= '0;
      wr_0_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick0 || pick1) begin
            if (sel_wr) begin
              wr_0_req  <= 1'b1;
              wr_0_addr <= sel_addr;
              wr_0_data <= sel_wdata;
              state     <= ST_WR_WAIT;
            end else begin
              rd_0_req  <= 1'b1;
              rd_0_addr <= sel_addr;
              state     <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (rd_0_ack) begin
            rd_0_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WR_WAIT: begin
          if (wr_0_ack) begin
            wr_0_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_outstanding <= '0;
      starve_cnt     <= '0;
      err_orphan_vld <= 1'b0;
    end else begin
      case ({grant_rd, pop})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
      if (pick0) starve_cnt <= '0;
      else if (c0_req && (starve_cnt < STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      if (rd_0_vld && tag_empty) err_orphan_vld <= 1'b1;
    end
  end

  // Read returns are routed by tag regardless of FSM state, one cycle after rd_0_vld.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_rvld  <= 1'b0;
      c1_rvld  <= 1'b0;
      c0_rdata <= '0;
      c1_rdata <= '0;
    end else begin
      c0_rvld <= pop && (tag_out == CLIENT_AGE);
      c1_rvld <= pop && (tag_out == CLIENT_PKT);
      if (pop && (tag_out == CLIENT_AGE)) c0_rdata <= rd_0_data;
      if (pop && (tag_out == CLIENT_PKT)) c1_rdata <= rd_0_data;
    end
  end

endmodule

// File: tb/tb_bf_sram_arbiter.sv
// Self-checking bench for bf_sram_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_bf_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_req, c0_wr, c1_req, c1_wr;
  logic [18:0] c0_addr, c1_addr;
  logic [63:0] c0_wdata, c1_wdata;
  logic        c0_gnt, c0_rvld, c1_gnt, c1_rvld;
  logic [63:0] c0_rdata, c1_rdata;
  logic        rd_0_req, rd_0_ack, rd_0_vld;
  logic [18:0] rd_0_addr;
  logic [63:0] rd_0_data;
  logic        wr_0_req, wr_0_ack;
  logic [18:0] wr_0_addr;
  logic [63:0] wr_0_data;
  logic [2:0]  rd_outstanding;
  logic        err_orphan_vld;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bf_sram_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_gnt(c0_gnt), .c0_rvld(c0_rvld), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_gnt(c1_gnt), .c1_rvld(c1_rvld), .c1_rdata(c1_rdata),
    .rd_0_req(rd_0_req), .rd_0_addr(rd_0_addr), .rd_0_ack(rd_0_ack),
    .rd_0_vld(rd_0_vld), .rd_0_data(rd_0_data),
    .wr_0_req(wr_0_req), .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data), .wr_0_ack(wr_0_ack),
    .rd_outstanding(rd_outstanding), .err_orphan_vld(err_orphan_vld)
  );

  typedef struct packed {
    logic r0, w0, r1, w1;
    logic e_g0, e_g1, e_rd, e_wr;
  } vec_t;

  vec_t vecs[8];

  task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_output(input string name, input logic act, input logic exp);
    check_value(name, 64'(act), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c0_req = 1'b0; c0_wr = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b0; c1_wr = 1'b0; c1_addr = '0; c1_wdata = '0;
    rd_0_ack = 1'b0; rd_0_vld = 1'b0; rd_0_data = '0; wr_0_ack = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one command from an IDLE arbiter, ack it in its first request cycle, return to IDLE.
  task automatic issue(input bit client, input bit wr, input logic [18:0] addr, input logic [63:0] data);
    if (client) begin c1_req = 1'b1; c1_wr = wr; c1_addr = addr; c1_wdata = data; end
    else        begin c0_req = 1'b1; c0_wr = wr; c0_addr = addr; c0_wdata = data; end
    #1;
    check_output("issue_gnt", client ? c1_gnt : c0_gnt, 1'b1);
    tick();
    c0_req = 1'b0; c1_req = 1'b0;
    if (wr) wr_0_ack = 1'b1; else rd_0_ack = 1'b1;
    tick();
    wr_0_ack = 1'b0; rd_0_ack = 1'b0;
  endtask

  // Reference-model state for the randomized run.
  bit          m_busy, m_wr, p0, p1, eg0, eg1, el0, el1, e_rv0, e_rv1, t;
  bit          tagq[$];
  logic [18:0] m_addr;
  logic [63:0] m_data, e_data;
  int          denials, acked;

  initial begin
    int req_cycles, c0_hits, c1_hits, gnt_extra;

    vecs[0] = 8'b0000_0000;
    vecs[1] = 8'b1000_1010;
    vecs[2] = 8'b1100_1001;
    vecs[3] = 8'b0010_0110;
    vecs[4] = 8'b0011_0101;
    vecs[5] = 8'b1010_0110;
    vecs[6] = 8'b1110_0110;
    vecs[7] = 8'b1011_0101;

    reset_dut();
    #1;
    check_output("reset_rd_req", rd_0_req, 1'b0);
    check_value("reset_outstanding", 64'(rd_outstanding), 64'd0);

    // Single-cycle arbitration decisions from a freshly reset arbiter.
    for (int i = 0; i < 8; i++) begin
      reset_dut();
      c0_req = vecs[i].r0; c0_wr = vecs[i].w0; c0_addr = 19'h111; c0_wdata = 64'h1111;
      c1_req = vecs[i].r1; c1_wr = vecs[i].w1; c1_addr = 19'h222; c1_wdata = 64'h2222;
      #1;
      check_output("vec_c0_gnt", c0_gnt, vecs[i].e_g0);
      check_output("vec_c1_gnt", c1_gnt, vecs[i].e_g1);
      tick();
      clear_inputs();
      #1;
      check_output("vec_rd_req", rd_0_req, vecs[i].e_rd);
      check_output("vec_wr_req", wr_0_req, vecs[i].e_wr);
      if (vecs[i].e_rd) check_value("vec_rd_addr", 64'(rd_0_addr), vecs[i].e_g1 ? 64'h222 : 64'h111);
      if (vecs[i].e_wr) check_value("vec_wr_data", wr_0_data, vecs[i].e_g1 ? 64'h2222 : 64'h1111);
    end

    // Single c1 read: ack on second request cycle, data three cycles later.
    reset_dut();
    c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 19'h00010;
    #1;
    check_output("rd1_c1_gnt", c1_gnt, 1'b1);
    check_output("rd1_c0_gnt", c0_gnt, 1'b0);
    tick();
    c1_req = 1'b0;
    req_cycles = 0; c0_hits = 0; c1_hits = 0; gnt_extra = 0;
    for (int i = 0; i < 8; i++) begin
      rd_0_ack = (i == 1); rd_0_vld = (i == 4); rd_0_data = 64'hAB;
      #1;
      if (rd_0_req) req_cycles++;
      if (c1_gnt) gnt_extra++;
      if (c0_rvld) c0_hits++;
      if (c1_rvld) begin
        c1_hits++;
        check_value("rd1_rdata", c1_rdata, 64'hAB);
        check_value("rd1_rvld_cycle", 64'(i), 64'd5);
      end
      if (i == 0) check_value("rd1_addr", 64'(rd_0_addr), 64'h10);
      tick();
    end
    check_value("rd1_req_cycles", 64'(req_cycles), 64'd2);
    check_value("rd1_c1_rvld_count", 64'(c1_hits), 64'd1);
    check_value("rd1_c0_rvld_count", 64'(c0_hits), 64'd0);
    check_value("rd1_extra_gnt", 64'(gnt_extra), 64'd0);
    check_value("rd1_outstanding", 64'(rd_outstanding), 64'd0);

    // Both clients write continuously: c0 wins once it has been denied STARVE_LIMIT cycles.
    reset_dut();
    c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 19'h5;
    c1_req = 1'b1; c1_wr = 1'b1; c1_addr = 19'h6;
    wr_0_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_output("starve_c0_gnt", c0_gnt, (i % 10) == 8);
      check_output("starve_c1_gnt", c1_gnt, ((i % 2) == 0) && ((i % 10) != 8));
      tick();
    end
    clear_inputs();

    // Four reads in flight block a fifth read but not a write; the first return unblocks it.
    reset_dut();
    for (int k = 0; k < 4; k++) issue(1'b0, 1'b0, 19'(k), 64'd0);
    #1;
    check_value("full_outstanding", 64'(rd_outstanding), 64'd4);
    c0_req = 1'b1; c0_wr = 1'b0; c0_addr = 19'h44;
    c1_req = 1'b1; c1_wr = 1'b1; c1_addr = 19'h55; c1_wdata = 64'h5555;
    #1;
    check_output("full_c0_held", c0_gnt, 1'b0);
    check_output("full_c1_wr_gnt", c1_gnt, 1'b1);
    tick();
    c1_req = 1'b0; wr_0_ack = 1'b1;
    #1;
    check_output("full_wr_req", wr_0_req, 1'b1);
    tick();
    wr_0_ack = 1'b0; rd_0_vld = 1'b1; rd_0_data = 64'h77;
    #1;
    check_output("full_c0_still_held", c0_gnt, 1'b0);
    tick();
    rd_0_vld = 1'b0;
    #1;
    check_output("full_c0_released", c0_gnt, 1'b1);
    check_output("full_c0_rvld", c0_rvld, 1'b1);
    check_value("full_outstanding_after", 64'(rd_outstanding), 64'd3);
    tick();
    c0_req = 1'b0; rd_0_ack = 1'b1;
    tick();
    rd_0_ack = 1'b0;
    #1;
    check_value("full_outstanding_refill", 64'(rd_outstanding), 64'd4);

    // Interleaved reads c0, c1, c0 return in issue order.
    reset_dut();
    issue(1'b0, 1'b0, 19'h100, 64'd0);
    issue(1'b1, 1'b0, 19'h200, 64'd0);
    issue(1'b0, 1'b0, 19'h300, 64'd0);
    for (int j = 0; j < 4; j++) begin
      rd_0_vld = (j < 3); rd_0_data = 64'(j + 1);
      #1;
      check_output("order_c0_rvld", c0_rvld, (j == 1) || (j == 3));
      check_output("order_c1_rvld", c1_rvld, j == 2);
      if (j > 0) check_value("order_rdata", (j == 2) ? c1_rdata : c0_rdata, 64'(j));
      tick();
    end
    rd_0_vld = 1'b0;

    // Orphan return sets a sticky error and is not delivered.
    reset_dut();
    rd_0_vld = 1'b1; rd_0_data = 64'h99;
    #1;
    check_output("orphan_err_before", err_orphan_vld, 1'b0);
    tick();
    rd_0_vld = 1'b0;
    #1;
    check_output("orphan_err", err_orphan_vld, 1'b1);
    check_output("orphan_c0_rvld", c0_rvld, 1'b0);
    check_output("orphan_c1_rvld", c1_rvld, 1'b0);
    tick();
    check_output("orphan_err_sticky", err_orphan_vld, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_output("orphan_err_cleared", err_orphan_vld, 1'b0);

    // Reset during WR_WAIT abandons the write and drops the outstanding read tag.
    reset_dut();
    issue(1'b1, 1'b0, 19'h7, 64'd0);
    c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 19'h8; c0_wdata = 64'hDEAD;
    #1;
    check_output("rstwr_gnt", c0_gnt, 1'b1);
    tick();
    c0_req = 1'b0;
    #1;
    check_output("rstwr_wr_req", wr_0_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_0_vld = 1'b1; rd_0_data = 64'h42;
    c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 19'h9;
    #1;
    check_output("rstwr_wr_req_low", wr_0_req, 1'b0);
    check_value("rstwr_outstanding", 64'(rd_outstanding), 64'd0);
    check_output("rstwr_idle_gnt", c1_gnt, 1'b1);
    tick();
    rd_0_vld = 1'b0; c1_req = 1'b0;
    #1;
    check_output("rstwr_late_vld_err", err_orphan_vld, 1'b1);
    check_output("rstwr_late_vld_c1", c1_rvld, 1'b0);

    // All outputs return to zero after reset from a dirty state.
    reset_dut();
    #1;
    check_value("reset_state_addrs", {26'd0, rd_0_addr, wr_0_addr}, 64'd0);
    check_value("reset_state_wdata", wr_0_data, 64'd0);
    check_value("reset_state_rdata", c0_rdata | c1_rdata, 64'd0);
    check_value("reset_state_flags",
                64'({rd_0_req, wr_0_req, c0_gnt, c1_gnt, c0_rvld, c1_rvld, err_orphan_vld}), 64'd0);
    check_value("reset_state_outstanding", 64'(rd_outstanding), 64'd0);

    // Randomized traffic against the reference model.
    m_busy = 0; m_wr = 0; p0 = 0; p1 = 0; e_rv0 = 0; e_rv1 = 0;
    m_addr = '0; m_data = '0; e_data = '0;
    tagq.delete(); denials = 0; acked = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!p0 && ($urandom_range(0, 2) == 0)) begin
        p0 = 1; c0_wr = 1'($urandom_range(0, 1)); c0_addr = 19'($urandom); c0_wdata = {$urandom, $urandom};
      end
      if (!p1 && ($urandom_range(0, 1) == 0)) begin
        p1 = 1; c1_wr = 1'($urandom_range(0, 1)); c1_addr = 19'($urandom); c1_wdata = {$urandom, $urandom};
      end
      c0_req = p0; c1_req = p1;
      rd_0_ack = m_busy && !m_wr && ($urandom_range(0, 1) == 1);
      wr_0_ack = m_busy && m_wr && ($urandom_range(0, 1) == 1);
      rd_0_vld = (acked > 0) && ($urandom_range(0, 2) == 0);
      rd_0_data = {$urandom, $urandom};
      #1;
      el0 = p0 && !m_busy && (c0_wr || (tagq.size() < 4));
      el1 = p1 && !m_busy && (c1_wr || (tagq.size() < 4));
      eg0 = 0; eg1 = 0;
      if (el0 && (denials >= 8)) eg0 = 1;
      else if (el1) eg1 = 1;
      else if (el0) eg0 = 1;
      check_output("rnd_c0_gnt", c0_gnt, eg0);
      check_output("rnd_c1_gnt", c1_gnt, eg1);
      check_output("rnd_rd_req", rd_0_req, m_busy && !m_wr);
      check_output("rnd_wr_req", wr_0_req, m_busy && m_wr);
      if (m_busy && !m_wr) check_value("rnd_rd_addr", 64'(rd_0_addr), 64'(m_addr));
      if (m_busy && m_wr) check_value("rnd_wr_data", wr_0_data, m_data);
      check_value("rnd_outstanding", 64'(rd_outstanding), 64'(tagq.size()));
      check_output("rnd_c0_rvld", c0_rvld, e_rv0);
      check_output("rnd_c1_rvld", c1_rvld, e_rv1);
      if (e_rv0) check_value("rnd_c0_rdata", c0_rdata, e_data);
      if (e_rv1) check_value("rnd_c1_rdata", c1_rdata, e_data);

      e_rv0 = 0; e_rv1 = 0;
      if (rd_0_vld) begin
        t = tagq.pop_front();
        e_rv0 = !t; e_rv1 = t; e_data = rd_0_data;
        acked--;
      end
      if (m_busy && (rd_0_ack || wr_0_ack)) begin
        if (!m_wr) acked++;
        m_busy = 0;
      end
      if (eg0 || eg1) begin
        m_busy = 1;
        m_wr   = eg1 ? c1_wr : c0_wr;
        m_addr = eg1 ? c1_addr : c0_addr;
        m_data = eg1 ? c1_wdata : c0_wdata;
        if (!m_wr) tagq.push_back(eg1);
      end
      if (eg0) denials = 0;
      else if (p0) denials++;
      if (eg0) p0 = 0;
      if (eg1) p1 = 0;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
